// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle CHUNK-bit-per-clock ripple add/sub (a,b,ci,sub in via in_valid/in_ready; sum,co,ovf out via out_valid/out_ready)
module chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r, w, w_nxt;
  logic [CHUNK-1:0] s_chunk;
  logic [IW-1:0] idx;
  logic carry, carry_nxt, last, ovf_nxt;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    {carry_nxt, s_chunk} = {1'b0, a_r[int'(idx)*CHUNK +: CHUNK]} + {1'b0, b_r[int'(idx)*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
    w_nxt = w;
    w_nxt[int'(idx)*CHUNK +: CHUNK] = s_chunk;
    last = idx == IW'(NCHUNK - 1);
    ovf_nxt = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (w_nxt[WIDTH-1] != a_r[WIDTH-1]);
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      w <= '0;
      carry <= 1'b0;
      idx <= '0;
      sum <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        a_r <= a;
        b_r <= b ^ {WIDTH{sub}};
        carry <= ci ^ sub;
        idx <= '0;
      end else if (state == RUN) begin
        w <= w_nxt;
        carry <= carry_nxt;
        idx <= idx + 1'b1;
        if (last) begin
          sum <= w_nxt;
          co <= carry_nxt;
          ovf <= ovf_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: scoreboard bench for chunked_adder at 16/4, 8/8 and 12/3
module tb_chunked_adder;
  logic clk = 0, reset = 1, out_ready = 1, ci = 0, sub = 0;
  logic [15:0] a = '0, b = '0;
  logic [2:0] iv = '0, ir, ov, co_o, ovf_o;
  logic [15:0] s0;
  logic [7:0] s1;
  logic [11:0] s2;
  logic [15:0] sw [3];
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {logic [15:0] s; logic c; logic o; int acc;} exp_t;
  exp_t q0[$], q1[$], q2[$];
  logic [2:0] ovp = '0;
  logic [15:0] held [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) u0 (.clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready), .sum(s0), .co(co_o[0]), .ovf(ovf_o[0]));
  chunked_adder #(.WIDTH(8), .CHUNK(8)) u1 (.clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready), .sum(s1), .co(co_o[1]), .ovf(ovf_o[1]));
  chunked_adder #(.WIDTH(12), .CHUNK(3)) u2 (.clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a[11:0]), .b(b[11:0]), .ci(ci), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .co(co_o[2]), .ovf(ovf_o[2]));

  assign sw[0] = s0;
  assign sw[1] = {8'h00, s1};
  assign sw[2] = {4'h0, s2};

  function automatic int nch(int d);
    return d == 1 ? 1 : 4;
  endfunction

  function automatic logic [17:0] model16(logic [15:0] x, logic [15:0] y, logic c, logic s);
    logic [15:0] be;
    logic [16:0] f;
    be = y ^ {16{s}};
    f = {1'b0, x} + {1'b0, be} + 17'(c ^ s);
    return {(x[15] == be[15]) && (f[15] != x[15]), f};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (!reset && ov[d] && !ovp[d]) begin
        if ((d == 0 ? q0.size() : d == 1 ? q1.size() : q2.size()) == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result dut%0d: got sum %0h expected none", d, sw[d]);
        end else begin
          case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("sum dut%0d", d), 32'(sw[d]), 32'(e.s));
          chk($sformatf("co dut%0d", d), 32'(co_o[d]), 32'(e.c));
          chk($sformatf("ovf dut%0d", d), 32'(ovf_o[d]), 32'(e.o));
          chk($sformatf("latency dut%0d", d), 32'(cyc - e.acc), 32'(nch(d)));
        end
        held[d] = sw[d];
      end else if (ov[d] && ovp[d]) begin
        chk($sformatf("hold_sum dut%0d", d), 32'(sw[d]), 32'(held[d]));
      end
    end
    ovp = ov;
  end

  task automatic issue(int d, logic [15:0] ia, logic [15:0] ib, logic ic, logic is,
                       logic [15:0] es, logic ec, logic eo);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ir[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir[d]) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: got in_ready 0 expected 1", d);
      return;
    end
    a = ia;
    b = ib;
    ci = ic;
    sub = is;
    iv[d] = 1'b1;
    e.s = es;
    e.c = ec;
    e.o = eo;
    e.acc = cyc + 1;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  task automatic rnd16();
    logic [15:0] x, y;
    logic c, s;
    logic [17:0] m;
    x = 16'($urandom);
    y = 16'($urandom);
    c = 1'($urandom);
    s = 1'($urandom);
    m = model16(x, y, c, s);
    issue(0, x, y, c, s, m[15:0], m[16], m[17]);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q0.size() + q1.size() + q2.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset in_ready", 32'(ir), 32'h7);
    chk("reset out_valid", 32'(ov), 32'h0);
    chk("reset sum", 32'(s0), 32'h0);
    chk("reset co_ovf", 32'({co_o, ovf_o}), 32'h0);
    reset = 0;
    issue(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    issue(0, 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    issue(0, 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
    issue(0, 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
    issue(0, 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
    issue(0, 16'h0007, 16'h0005, 1, 1, 16'h0001, 1, 0);
    issue(0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    repeat (6) rnd16();
    issue(1, 16'h007F, 16'h0001, 0, 0, 16'h0080, 0, 1);
    issue(1, 16'h00FF, 16'h0001, 1, 0, 16'h0001, 1, 0);
    issue(1, 16'h0010, 16'h0020, 0, 1, 16'h00F0, 0, 0);
    issue(1, 16'h0080, 16'h0001, 0, 1, 16'h007F, 1, 1);
    issue(2, 16'h07FF, 16'h0001, 0, 0, 16'h0800, 0, 1);
    issue(2, 16'h0FFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
    issue(2, 16'h0ABC, 16'h0123, 0, 0, 16'h0BDF, 0, 0);
    issue(2, 16'h0000, 16'h0001, 0, 1, 16'h0FFF, 0, 0);
    issue(2, 16'h0123, 16'h0023, 1, 1, 16'h00FF, 1, 0);
    drain();
    out_ready = 0;
    issue(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    n = 0;
    while (!ov[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp reached done", 32'(ov[0]), 32'h1);
    for (int i = 0; i < 10; i++) begin
      a = 16'hAAAA;
      b = 16'h5555;
      iv[0] = 1'b1;
      @(negedge clk);
      chk("bp in_ready", 32'(ir[0]), 32'h0);
      chk("bp out_valid", 32'(ov[0]), 32'h1);
    end
    iv[0] = 1'b0;
    out_ready = 1;
    @(negedge clk);
    chk("release out_valid", 32'(ov[0]), 32'h0);
    chk("release in_ready", 32'(ir[0]), 32'h1);
    chk("release sum kept", 32'(s0), 32'h2345);
    issue(0, 16'h0F0F, 16'h00F0, 1, 0, 16'h1000, 0, 0);
    drain();
    issue(0, 16'h1111, 16'h2222, 0, 0, 16'h3333, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    q0.delete();
    chk("abort in_ready", 32'(ir[0]), 32'h1);
    chk("abort out_valid", 32'(ov[0]), 32'h0);
    chk("abort sum", 32'(s0), 32'h0);
    issue(0, 16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1);
    issue(0, 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
